// File: rtl/fetch_iq_pkg.sv
// Shared definitions for the fetch instruction queue: default widths,
// the {inst, pc} entry layout and the pointer-width helper.
package fetch_iq_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 32;
    localparam int DEPTH_DEF  = 8;

    // One queue entry at the default widths.
    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [PC_W_DEF-1:0]   pc;
    } iq_entry_t;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/iq_ptr_ctr.sv
// Wrap-around queue pointer: async active-low reset, synchronous clear
// (flush), and increment enable. The queue depth is a power of two, so
// natural binary overflow wraps DEPTH-1 back to 0.
module iq_ptr_ctr #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_r;

    // Pointer register: clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (clr) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {inst, pc} pairs
// with valid/ready handshakes on both sides and a single-cycle flush.
// Optional zero-latency path from push_* to pop_* when the queue is empty,
// enabled with the macro FETCH_IQ_BYPASS_EN.
module fetch_inst_queue
    import fetch_iq_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [INST_W-1:0]          push_inst,
    input  logic [PC_W-1:0]            push_pc,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [INST_W-1:0]          pop_inst,
    output logic [PC_W-1:0]            pop_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W   = ptr_width(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = INST_W + PC_W;

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_s;
    logic               full_s;
    logic               empty_s;
    logic               bypass_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic [ENTRY_W-1:0] head_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Ready depends on stored occupancy only, never on pop_ready.
    assign push_ready = !full_s;

`ifdef FETCH_IQ_BYPASS_EN
    // Empty queue with an incoming entry: present it straight to decode.
    assign bypass_s = empty_s & push_valid & !flush;
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed entry that decode takes this cycle is never stored.
    assign wr_en_s = push_valid & !full_s & !flush & !(bypass_s & pop_ready);
    // Only stored entries advance the read pointer.
    assign rd_en_s = !empty_s & pop_ready & !flush;

    assign pop_valid = !empty_s | bypass_s;
    assign head_s    = mem_r[rd_ptr_s];
    assign count     = count_r;

    iq_ptr_ctr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst),
        .clr   (flush),
        .inc   (wr_en_s),
        .ptr   (wr_ptr_s)
    );

    iq_ptr_ctr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst),
        .clr   (flush),
        .inc   (rd_en_s),
        .ptr   (rd_ptr_s)
    );

    // Entry storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_s] <= {push_inst, push_pc};
        end
    end

    // Occupancy: flush clears, push-only +1, pop-only -1, both keeps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head data: bypassed entry, stored head, or zeros so nothing stale leaks.
    always_comb begin
        pop_inst = {INST_W{1'b0}};
        pop_pc   = {PC_W{1'b0}};
        if (bypass_s) begin
            pop_inst = push_inst;
            pop_pc   = push_pc;
        end else if (!empty_s) begin
            pop_inst = head_s[ENTRY_W-1:PC_W];
            pop_pc   = head_s[PC_W-1:0];
        end else begin
            pop_inst = {INST_W{1'b0}};
            pop_pc   = {PC_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed self-checking bench for fetch_inst_queue (DEPTH=8, 32-bit fields).
// A scoreboard queue holds entries accepted by the model; every cycle the
// head outputs, handshakes and occupancy are compared against the model.
module tb_fetch_inst_queue;
    import fetch_iq_pkg::*;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_inst;
    logic [31:0] push_pc;
    logic        pop_valid;
    logic        pop_ready;
    logic [31:0] pop_inst;
    logic [31:0] pop_pc;
    logic [3:0]  count;

    int checks;
    int errors;
    int mcnt;
    iq_entry_t sb[$];

    fetch_inst_queue #(.INST_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_inst  (push_inst),
        .push_pc    (push_pc),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_inst   (pop_inst),
        .pop_pc     (pop_pc),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs against the model,
    // advance the model, clock, then check the new occupancy.
    task automatic cycle(input logic pv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic pr, input logic fl);
        logic      exp_ready;
        logic      byp;
        logic      exp_pv;
        iq_entry_t e;
        push_valid = pv;
        push_inst  = inst;
        push_pc    = pc;
        pop_ready  = pr;
        flush      = fl;
        #1;
        exp_ready = (mcnt != DEPTH);
`ifdef FETCH_IQ_BYPASS_EN
        byp = (mcnt == 0) && pv && !fl;
`else
        byp = 1'b0;
`endif
        exp_pv = (mcnt != 0) || byp;
        check("push_ready", {63'd0, push_ready}, {63'd0, exp_ready});
        check("pop_valid", {63'd0, pop_valid}, {63'd0, exp_pv});
        if (byp) begin
            e.inst = inst;
            e.pc   = pc;
        end else if (mcnt != 0) begin
            e = sb[0];
        end else begin
            e = '0;
        end
        check("pop_inst", {32'd0, pop_inst}, {32'd0, e.inst});
        check("pop_pc", {32'd0, pop_pc}, {32'd0, e.pc});
        if (fl) begin
            sb.delete();
            mcnt = 0;
        end else begin
            if ((mcnt != 0) && pr) begin
                void'(sb.pop_front());
                mcnt = mcnt - 1;
            end
            if (pv && exp_ready && !(byp && pr)) begin
                e.inst = inst;
                e.pc   = pc;
                sb.push_back(e);
                mcnt = mcnt + 1;
            end
        end
        @(posedge clk);
        #1;
        check("count", {60'd0, count}, 64'(mcnt));
    endtask

    task automatic idle_n(input int n, input logic pr);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 32'd0, 32'd0, pr, 1'b0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        mcnt       = 0;
        rst        = 1'b0;
        flush      = 1'b0;
        push_valid = 1'b0;
        push_inst  = 32'd0;
        push_pc    = 32'd0;
        pop_ready  = 1'b0;

        // 1. Reset, then idle.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_count", {60'd0, count}, 64'd0);
        check("rst_pop_valid", {63'd0, pop_valid}, 64'd0);
        check("rst_push_ready", {63'd0, push_ready}, 64'd1);
        check("rst_pop_inst", {32'd0, pop_inst}, 64'd0);
        check("rst_pop_pc", {32'd0, pop_pc}, 64'd0);
        idle_n(2, 1'b0);

        // 2. Fill to DEPTH, 9th push held off, drain in order.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
        end
        check("full_count", {60'd0, count}, 64'd8);
        check("full_push_ready", {63'd0, push_ready}, 64'd0);
        cycle(1'b1, 32'h108, 32'h1020, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end
        idle_n(1, 1'b1);
        check("drained_pop_valid", {63'd0, pop_valid}, 64'd0);

        // 3. Wrap-around.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h50 + 32'(i), 32'h500 + 32'(4 * i), 1'b0, 1'b0);
        idle_n(5, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'hA0 + 32'(i), 32'hA00 + 32'(4 * i), 1'b0, 1'b0);
        idle_n(6, 1'b1);
        check("wrap_count", {60'd0, count}, 64'd0);

        // 4. Simultaneous push+pop at count 3, full and empty.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC0 + 32'(i), 32'hC00 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'hC3, 32'hC0C, 1'b1, 1'b0);
        check("pp3_count", {60'd0, count}, 64'd3);
        idle_n(3, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hD0 + 32'(i), 32'hD00 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'hD8, 32'hD20, 1'b1, 1'b0);
        check("ppfull_count", {60'd0, count}, 64'd7);
        idle_n(7, 1'b1);
        cycle(1'b1, 32'hE0, 32'hE00, 1'b1, 1'b0);
        idle_n(2, 1'b1);

        // 5. Flush with concurrent push and pop.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hF0 + 32'(i), 32'hF00 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 32'h770, 1'b1, 1'b1);
        check("flush_count", {60'd0, count}, 64'd0);
        check("flush_pop_valid", {63'd0, pop_valid}, 64'd0);
        cycle(1'b1, 32'h55, 32'h550, 1'b0, 1'b0);
        check("post_flush_head", {32'd0, pop_inst}, 64'h55);
        idle_n(2, 1'b1);

`ifdef FETCH_IQ_BYPASS_EN
        // 6. Bypass: consumed in the same cycle, then held when not taken.
        cycle(1'b1, 32'hBEEF, 32'h2000, 1'b1, 1'b0);
        check("byp_count", {60'd0, count}, 64'd0);
        cycle(1'b1, 32'hBEEF, 32'h2004, 1'b0, 1'b0);
        check("byp_hold_count", {60'd0, count}, 64'd1);
        idle_n(1, 1'b0);
        check("byp_hold_head", {32'd0, pop_inst}, 64'hBEEF);
        idle_n(2, 1'b1);
`endif

        // Reset asserted mid-operation clears state immediately.
        cycle(1'b1, 32'h31, 32'h310, 1'b0, 1'b0);
        cycle(1'b1, 32'h32, 32'h314, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_count", {60'd0, count}, 64'd0);
        check("midrst_pop_valid", {63'd0, pop_valid}, 64'd0);
        push_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_push_ignored", {60'd0, count}, 64'd0);
        sb.delete();
        mcnt = 0;
        rst  = 1'b1;
        idle_n(1, 1'b0);
        cycle(1'b1, 32'h60, 32'h600, 1'b0, 1'b0);
        idle_n(2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
